// File: rtl/video_fb_reader.sv
// Framebuffer scan-out reader: turns the timing generator's sx/sy into bank-addressed
// reads and produces pixel/de/sync aligned 3 cycles later. VIDEO_TEST_PATTERN_EN adds a colour-bar override.
`default_nettype none

module video_fb_reader #(
    parameter int HRes      = 480,
    parameter int VRes      = 272,
    parameter int AddrWidth = 17,
    parameter int DataWidth = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 hsync,
    input  logic                 vsync,
    input  logic [9:0]           sx,
    input  logic [9:0]           sy,
    input  logic                 swap_req,
`ifdef VIDEO_TEST_PATTERN_EN
    input  logic                 test_en,
`endif
    output logic [AddrWidth:0]   mem_addr,
    output logic                 mem_en,
    input  logic [DataWidth-1:0] mem_rdata,
    output logic [DataWidth-1:0] rgb,
    output logic                 de,
    output logic                 hsync_o,
    output logic                 vsync_o,
    output logic                 disp_bank,
    output logic                 swap_ack
);

    localparam logic [9:0] HResW = 10'(HRes);
    localparam logic [9:0] VResW = 10'(VRes);

    logic                 pix_active;
    logic                 frame_origin;
    logic                 blank_start;
    logic                 rd_active;
    logic                 do_swap;
    logic [AddrWidth-1:0] rd_idx;
    logic [DataWidth-1:0] pix_src;

    logic [AddrWidth-1:0] pix_cnt_q, pix_cnt_d;
    logic                 synced_q, synced_d;
    logic                 disp_bank_q, disp_bank_d;
    logic                 swap_pending_q, swap_pending_d;
    logic                 swap_ack_q;
    logic [AddrWidth:0]   mem_addr_q, mem_addr_d;
    logic                 mem_en_q;
    logic                 act_d2_q;
    logic                 de_q;
    logic [DataWidth-1:0] rgb_q, rgb_d;
    logic                 hs_d1_q, hs_d2_q, hs_d3_q;
    logic                 vs_d1_q, vs_d2_q, vs_d3_q;

    assign pix_active   = (sx < HResW) && (sy < VResW);
    assign frame_origin = (sx == 10'd0) && (sy == 10'd0);
    assign blank_start  = (sx == 10'd0) && (sy == VResW);
    // After a reset the pixel counter no longer matches the raster, so reads wait for the next frame origin.
    assign rd_active    = pix_active && (synced_q || frame_origin);
    assign do_swap      = blank_start && (swap_pending_q || swap_req);

    always_comb begin
        pix_cnt_d = pix_cnt_q;
        rd_idx    = pix_cnt_q;
        if (rd_active) begin
            if (frame_origin) begin
                rd_idx    = '0;
                pix_cnt_d = AddrWidth'(1);
            end else begin
                pix_cnt_d = pix_cnt_q + AddrWidth'(1);
            end
        end
        synced_d       = synced_q || frame_origin;
        mem_addr_d     = {disp_bank_q, rd_idx};
        disp_bank_d    = disp_bank_q ^ do_swap;
        swap_pending_d = do_swap ? 1'b0 : (swap_pending_q || swap_req);
    end

`ifdef VIDEO_TEST_PATTERN_EN
    localparam int BarW = HRes / 8;

    logic [9:0]           sx_d1_q, sx_d2_q;
    logic [9:0]           bar_raw;
    logic [2:0]           bar_sel;
    logic [DataWidth-1:0] bar_rgb;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sx_d1_q <= '0;
            sx_d2_q <= '0;
        end else begin
            sx_d1_q <= sx;
            sx_d2_q <= sx_d1_q;
        end
    end

    // Columns past the last full bar fall into bar 7 (black).
    always_comb begin
        bar_raw = sx_d2_q / 10'(BarW);
        bar_sel = (bar_raw > 10'd7) ? 3'd7 : bar_raw[2:0];
        case (bar_sel)
            3'd0:    bar_rgb = DataWidth'(16'hFFFF);
            3'd1:    bar_rgb = DataWidth'(16'hFFE0);
            3'd2:    bar_rgb = DataWidth'(16'h07FF);
            3'd3:    bar_rgb = DataWidth'(16'h07E0);
            3'd4:    bar_rgb = DataWidth'(16'hF81F);
            3'd5:    bar_rgb = DataWidth'(16'hF800);
            3'd6:    bar_rgb = DataWidth'(16'h001F);
            default: bar_rgb = DataWidth'(16'h0000);
        endcase
        pix_src = test_en ? bar_rgb : mem_rdata;
    end
`else
    always_comb begin
        pix_src = mem_rdata;
    end
`endif

    always_comb begin
        rgb_d = act_d2_q ? pix_src : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix_cnt_q      <= '0;
            synced_q       <= 1'b0;
            disp_bank_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_ack_q     <= 1'b0;
            mem_addr_q     <= '0;
            mem_en_q       <= 1'b0;
            act_d2_q       <= 1'b0;
            de_q           <= 1'b0;
            rgb_q          <= '0;
            hs_d1_q        <= 1'b0;
            hs_d2_q        <= 1'b0;
            hs_d3_q        <= 1'b0;
            vs_d1_q        <= 1'b0;
            vs_d2_q        <= 1'b0;
            vs_d3_q        <= 1'b0;
        end else begin
            pix_cnt_q      <= pix_cnt_d;
            synced_q       <= synced_d;
            disp_bank_q    <= disp_bank_d;
            swap_pending_q <= swap_pending_d;
            swap_ack_q     <= do_swap;
            mem_addr_q     <= mem_addr_d;
            mem_en_q       <= rd_active;
            act_d2_q       <= mem_en_q;
            de_q           <= act_d2_q;
            rgb_q          <= rgb_d;
            hs_d1_q        <= hsync;
            hs_d2_q        <= hs_d1_q;
            hs_d3_q        <= hs_d2_q;
            vs_d1_q        <= vsync;
            vs_d2_q        <= vs_d1_q;
            vs_d3_q        <= vs_d2_q;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_en    = mem_en_q;
    assign rgb       = rgb_q;
    assign de        = de_q;
    assign hsync_o   = hs_d3_q;
    assign vsync_o   = vs_d3_q;
    assign disp_bank = disp_bank_q;
    assign swap_ack  = swap_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_video_fb_reader.sv
// Directed bench for video_fb_reader: full-width lines on a short frame so that several
// frames (swaps, reset mid-frame, optional test pattern) fit in a short run.
`timescale 1ns/1ps

module tb_video_fb_reader;

    localparam int HR = 480;
    localparam int VR = 8;
    localparam int HT = 488;
    localparam int VT = 10;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        swap_req = 1'b0;
    logic [9:0]  sx = 10'd0;
    logic [9:0]  sy = 10'd0;
    logic [17:0] mem_addr;
    logic        mem_en;
    logic [15:0] mem_rdata = 16'hDEAD;
    logic [15:0] rgb;
    logic        de, hsync_o, vsync_o, disp_bank, swap_ack;
`ifdef VIDEO_TEST_PATTERN_EN
    logic        test_en = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int h0x = -1, h0y = -1, h1x = -1, h1y = -1, h2x = -1, h2y = -1;
    int acks;
    bit checks_on = 1'b1;
    bit tp_mode   = 1'b0;

    always #5 clk = ~clk;

    video_fb_reader #(
        .HRes(HR), .VRes(VR), .AddrWidth(17), .DataWidth(16)
    ) dut (
        .clk(clk), .rstn(rstn), .hsync(hsync), .vsync(vsync),
        .sx(sx), .sy(sy), .swap_req(swap_req),
`ifdef VIDEO_TEST_PATTERN_EN
        .test_en(test_en),
`endif
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_rdata(mem_rdata),
        .rgb(rgb), .de(de), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .disp_bank(disp_bank), .swap_ack(swap_ack)
    );

    function automatic logic [15:0] exp_data(input logic [17:0] a);
        return a[15:0] ^ 16'h1234 ^ (a[17] ? 16'h8000 : 16'h0000);
    endfunction

    // Synchronous-read memory: data appears the cycle after mem_en.
    always @(posedge clk) if (mem_en) mem_rdata <= exp_data(mem_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check_eq({tag, "_en"},   32'(mem_en),   32'd0);
        check_eq({tag, "_rgb"},  32'(rgb),      32'd0);
        check_eq({tag, "_de"},   32'(de),       32'd0);
        check_eq({tag, "_hs"},   32'(hsync_o),  32'd0);
        check_eq({tag, "_vs"},   32'(vsync_o),  32'd0);
        check_eq({tag, "_bank"}, 32'(disp_bank), 32'd0);
        check_eq({tag, "_ack"},  32'(swap_ack), 32'd0);
    endtask

    task automatic run_frame(input int rx1, input int ry1, input int rx2, input int ry2,
                             input int rst_y, input bit bank_pre, input bit exp_swap,
                             input bit bank_post);
        logic [17:0] base;
        base = {bank_pre, 17'd0};
        acks = 0;
        checks_on = 1'b1;
        for (int y = 0; y < VT; y++) begin
            for (int x = 0; x < HT; x++) begin
                @(negedge clk);
                if (swap_ack) acks++;
                if (checks_on) begin
                    if (h0x == 0 && h0y == 0) begin
                        check_eq("origin_addr", 32'(mem_addr), 32'(base));
                        check_eq("origin_en", 32'(mem_en), 32'd1);
                    end
                    if (h0x == HR-1 && h0y == 0)    check_eq("addr_479_0", 32'(mem_addr), 32'(base + 18'd479));
                    if (h0x == 0 && h0y == 1)       check_eq("addr_0_1", 32'(mem_addr), 32'(base + 18'd480));
                    if (h0x == HR-1 && h0y == VR-1) check_eq("addr_last", 32'(mem_addr), 32'(base + 18'd3839));
                    if (h0x == 483 && h0y == 2)     check_eq("blank_en", 32'(mem_en), 32'd0);
                    if (h2x == 0 && h2y == 0) begin
                        check_eq("origin_de", 32'(de), 32'd1);
                        check_eq("origin_hs", 32'(hsync_o), 32'd0);
                        if (!tp_mode) check_eq("origin_rgb", 32'(rgb), 32'(exp_data(base)));
                    end
                    if (h2x == HR-1 && h2y == 0 && !tp_mode)
                        check_eq("rgb_479_0", 32'(rgb), 32'(exp_data(base + 18'd479)));
                    if (h2x == 483 && h2y == 2) begin
                        check_eq("blank_rgb", 32'(rgb), 32'd0);
                        check_eq("blank_de", 32'(de), 32'd0);
                    end
                    if (tp_mode && h2y == 1) begin
                        if (h2x == 0)   check_eq("tp_sx0",   32'(rgb), 32'h0000FFFF);
                        if (h2x == 60)  check_eq("tp_sx60",  32'(rgb), 32'h0000FFE0);
                        if (h2x == 120) check_eq("tp_sx120", 32'(rgb), 32'h000007FF);
                        if (h2x == 479) check_eq("tp_sx479", 32'(rgb), 32'h00000000);
                    end
                end else if (h0x == HR-1 && h0y == VR-1) begin
                    check_eq("post_rst_en", 32'(mem_en), 32'd0);
                end
                if (h2y == 2 && (h2x == 481 || h2x == 482 || h2x == 485 || h2x == 486))
                    check_eq("hsync_dly", 32'(hsync_o), (h2x == 482 || h2x == 485) ? 32'd1 : 32'd0);
                if (h2x == 0 && h2y == VT-1)    check_eq("vsync_dly_hi", 32'(vsync_o), 32'd1);
                if (h2x == HT-1 && h2y == VT-2) check_eq("vsync_dly_lo", 32'(vsync_o), 32'd0);
                if (h0x == 0 && h0y == VR) begin
                    check_eq("swap_ack", 32'(swap_ack), 32'(exp_swap));
                    check_eq("bank_post", 32'(disp_bank), 32'(bank_post));
                end
                if (h0x == 1 && h0y == VR) check_eq("ack_width", 32'(swap_ack), 32'd0);

                h2x = h1x; h2y = h1y;
                h1x = h0x; h1y = h0y;
                h0x = x;   h0y = y;
                sx       = 10'(x);
                sy       = 10'(y);
                hsync    = (x >= 482 && x < 486);
                vsync    = (y == VT-1);
                swap_req = (x == rx1 && y == ry1) || (x == rx2 && y == ry2);
                if (x == 100 && y == rst_y) begin
                    #2 rstn = 1'b0;
                    #1 check_all_zero("rst_async");
                    #1 rstn = 1'b1;
                    checks_on = 1'b0;
                end
            end
        end
        check_eq("ack_count", 32'(acks), 32'(exp_swap));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("rst_hold");
        hsync = 1'b0;
        vsync = 1'b0;
        sx    = 10'(HT-1);
        sy    = 10'(VT-2);
        rstn  = 1'b1;
        @(negedge clk);

        run_frame(-1, -1, -1, -1, -1, 1'b0, 1'b0, 1'b0);
        run_frame( 5,  3, -1, -1, -1, 1'b0, 1'b1, 1'b1);
        run_frame( 5,  2,  7,  4, -1, 1'b1, 1'b1, 1'b0);
        run_frame( 0, VR, -1, -1, -1, 1'b0, 1'b1, 1'b1);
        run_frame( 5,  2, -1, -1,  4, 1'b1, 1'b0, 1'b0);
        run_frame(-1, -1, -1, -1, -1, 1'b0, 1'b0, 1'b0);
`ifdef VIDEO_TEST_PATTERN_EN
        test_en = 1'b1;
        tp_mode = 1'b1;
        run_frame(-1, -1, -1, -1, -1, 1'b0, 1'b0, 1'b0);
        test_en = 1'b0;
        tp_mode = 1'b0;
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
